apb_req_arbiter: RTL and testbench
==================================

APB_REQ_ARBITER -- requirements
Module: apb_req_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4; number of requester ports, range 2..16.
REQ-002 Parameter ADDR_WIDTH, default 32; APB address width.
REQ-003 Parameter DATA_WIDTH, default 32; APB data width; STRB_WIDTH = ceil(DATA_WIDTH/8).
REQ-004 Parameter TIMEOUT_CYCLES, default 256; ACCESS-phase wait limit; 0 disables the timeout.
REQ-005 The block SHALL use one clock, and its reset SHALL be asynchronous and active-high.
REQ-006 clk_i  in  1  clock, all state on rising edge.
REQ-007 rst_i  in  1  async active-high reset.
REQ-008 req_valid_i  in  NUM_REQ  per-requester transfer request.
REQ-009 req_ready_o  out  NUM_REQ  one-hot, one-cycle request acceptance.
REQ-010 req_addr_i / req_wdata_i / req_strb_i / req_write_i  in  NUM_REQ x (ADDR_WIDTH / DATA_WIDTH / STRB_WIDTH / 1)  per-requester payload.
REQ-011 rsp_valid_o  out  NUM_REQ  one-hot, one-cycle completion pulse to the owner.
REQ-012 rsp_rdata_o  out  DATA_WIDTH  read data, shared, valid with rsp_valid_o.
REQ-013 rsp_slverr_o  out  1  error, shared, valid with rsp_valid_o.
REQ-014 paddr_o, psel_o, penable_o, pwrite_o, pwdata_o, pstrb_o  out  APB4 master request, widths per APB.
REQ-015 pready_i, prdata_i, pslverr_i  in  APB4 completer response.

Function
REQ-016 The FSM SHALL have exactly the states IDLE, SETUP, and ACCESS.
REQ-017 In IDLE, when any req_valid_i bit is set, the block SHALL pick the winner round-robin, pulse req_ready_o[winner], latch that requester's payload and owner index, and go to SETUP.
REQ-018 Round-robin SHALL search upward from pointer ptr with wrap at NUM_REQ-1; after a grant to i, ptr SHALL become (i+1) mod NUM_REQ; ptr SHALL be 0 after reset.
REQ-019 In SETUP, psel_o=1 and penable_o=0; the block SHALL go to ACCESS unconditionally.
REQ-020 In ACCESS, psel_o=1 and penable_o=1; paddr/pwrite/pwdata/pstrb SHALL hold the latched values from SETUP through completion.
REQ-021 When ACCESS sees pready_i=1, the next cycle SHALL pulse rsp_valid_o[owner] with registered prdata_i (rdata=0 on writes) and pslverr_i, and the FSM SHALL return to IDLE.
REQ-022 The IDLE cycle that carries rsp_valid_o SHALL also accept a new request, giving a 3-cycle minimum accept-to-accept spacing.
REQ-023 A wait counter SHALL count ACCESS cycles with pready_i=0; when it reaches TIMEOUT_CYCLES (if nonzero), the block SHALL end the transfer with rsp_slverr_o=1, rsp_rdata_o=0, drop psel_o, and return to IDLE.
REQ-024 The wait counter SHALL be wide enough for TIMEOUT_CYCLES without wrapping and SHALL clear on entry to SETUP.
REQ-025 Requesters SHALL hold req_valid_i and payload stable until req_ready_o; the block SHALL not sample a requester's payload except in its acceptance cycle.
REQ-026 A requester that drops req_valid_i before acceptance SHALL not be granted; non-owner req_valid_i changes SHALL not affect an ongoing transfer.
REQ-027 Outside SETUP/ACCESS, psel_o and penable_o SHALL be 0, and pwdata_o/paddr_o SHALL hold their last values.

Reset
REQ-028 rst_i SHALL immediately force state=IDLE, ptr=0, counter=0, and all outputs (including psel_o, penable_o, req_ready_o, rsp_valid_o, data/addr) to 0, including mid-transfer; the aborted owner receives no response.

Structure
REQ-029 Package apb_arb_pkg SHALL hold the state enum and the owner-index width function clog2(NUM_REQ).
REQ-030 Winner selection SHALL be a separate combinational sub-module apb_rr_pick (inputs req vector and ptr; outputs one-hot grant, index, and any).

Verification
REQ-031 Single read, req0 addr 0x10, pready_i=1 in first ACCESS, prdata 0xDEADBEEF -> ready0 in cycle 0, SETUP in cycle 1, ACCESS in cycle 2, rsp_valid[0] with rdata 0xDEADBEEF and slverr 0 in cycle 3.
REQ-032 All four requesters valid continuously after reset -> grant order 0,1,2,3,0, with accepts 3 cycles apart.
REQ-033 Write with pready_i low for 5 ACCESS cycles -> penable held for 6 cycles, paddr/pwdata stable throughout, rsp_valid once.
REQ-034 TIMEOUT_CYCLES=8 with pready_i never high -> after 8 ACCESS cycles, psel drops, rsp_slverr_o=1, and rdata=0.
REQ-035 rst_i asserted during ACCESS -> psel/penable go 0 asynchronously, no rsp_valid; after release, the next grant goes to req0.
REQ-036 pslverr_i=1 with pready_i=1 -> rsp_slverr_o=1 for that owner only, and the next request proceeds normally.

Source files
------------

// File: rtl/apb_arb_pkg.sv
// Shared types and helpers for the APB request arbiter.
package apb_arb_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSetup  = 2'd1,
    StAccess = 2'd2
  } arb_state_e;

  // Bits needed to hold values 0..n-1; never less than one bit.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) begin
      w++;
    end
    return w;
  endfunction

endpackage

// File: rtl/apb_rr_pick.sv
// Round-robin winner selection: first asserted request at or above ptr, wrapping.
module apb_rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               any_o
);

  always_comb begin
    logic [IDX_W-1:0] cand;
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    cand    = '0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      cand = IDX_W'((32'(ptr_i) + off) % NUM_REQ);
      if (!any_o && req_i[cand]) begin
        any_o         = 1'b1;
        idx_o         = cand;
        grant_o[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/apb_req_arbiter.sv
// Multi-requester front end for a single APB4 master port with round-robin
// arbitration and an optional ACCESS-phase timeout.
module apb_req_arbiter
  import apb_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256,
  localparam int unsigned STRB_WIDTH    = (DATA_WIDTH + 7) / 8
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic [NUM_REQ-1:0]                    req_valid_i,
  output logic [NUM_REQ-1:0]                    req_ready_o,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]    req_addr_i,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]    req_wdata_i,
  input  logic [NUM_REQ-1:0][STRB_WIDTH-1:0]    req_strb_i,
  input  logic [NUM_REQ-1:0]                    req_write_i,
  output logic [NUM_REQ-1:0]                    rsp_valid_o,
  output logic [DATA_WIDTH-1:0]                 rsp_rdata_o,
  output logic                                  rsp_slverr_o,
  output logic [ADDR_WIDTH-1:0]                 paddr_o,
  output logic                                  psel_o,
  output logic                                  penable_o,
  output logic                                  pwrite_o,
  output logic [DATA_WIDTH-1:0]                 pwdata_o,
  output logic [STRB_WIDTH-1:0]                 pstrb_o,
  input  logic                                  pready_i,
  input  logic [DATA_WIDTH-1:0]                 prdata_i,
  input  logic                                  pslverr_i
);

  localparam int unsigned IDX_W = clog2(NUM_REQ);
  localparam int unsigned CNT_W = clog2(TIMEOUT_CYCLES + 1);

  arb_state_e state_q, state_d;

  logic [IDX_W-1:0]      ptr_q;
  logic [IDX_W-1:0]      owner_q;
  logic [CNT_W-1:0]      wait_cnt_q;
  logic [CNT_W-1:0]      wait_inc;
  logic [NUM_REQ-1:0]    grant;
  logic [IDX_W-1:0]      pick_idx;
  logic                  pick_any;
  logic                  accept;
  logic                  done_ok;
  logic                  timeout_hit;

  logic [ADDR_WIDTH-1:0] paddr_q;
  logic [DATA_WIDTH-1:0] pwdata_q;
  logic [STRB_WIDTH-1:0] pstrb_q;
  logic                  pwrite_q;
  logic [NUM_REQ-1:0]    rsp_valid_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;
  logic                  rsp_slverr_q;

  apb_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req_i   (req_valid_i),
    .ptr_i   (ptr_q),
    .grant_o (grant),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  assign accept   = (state_q == StIdle) && pick_any;
  assign done_ok  = (state_q == StAccess) && pready_i;
  assign wait_inc = wait_cnt_q + CNT_W'(1);
  // Fires on the ACCESS cycle whose stall would bring the count to the limit.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (state_q == StAccess) && !pready_i &&
                       (wait_inc == CNT_W'(TIMEOUT_CYCLES));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (pick_any) state_d = StSetup;
      StSetup:  state_d = StAccess;
      StAccess: if (pready_i || timeout_hit) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    psel_o      = (state_q == StSetup) || (state_q == StAccess);
    penable_o   = (state_q == StAccess);
    // Gated by reset so no acceptance is signalled while the block is held.
    req_ready_o = ((state_q == StIdle) && !rst_i) ? grant : '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q        <= '0;
      owner_q      <= '0;
      wait_cnt_q   <= '0;
      paddr_q      <= '0;
      pwdata_q     <= '0;
      pstrb_q      <= '0;
      pwrite_q     <= 1'b0;
      rsp_valid_q  <= '0;
      rsp_rdata_q  <= '0;
      rsp_slverr_q <= 1'b0;
    end else begin
      rsp_valid_q <= '0;
      if (accept) begin
        paddr_q    <= req_addr_i[pick_idx];
        pwdata_q   <= req_wdata_i[pick_idx];
        pstrb_q    <= req_strb_i[pick_idx];
        pwrite_q   <= req_write_i[pick_idx];
        owner_q    <= pick_idx;
        wait_cnt_q <= '0;
        ptr_q      <= (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + IDX_W'(1);
      end else if ((state_q == StAccess) && !pready_i && (TIMEOUT_CYCLES != 0)) begin
        wait_cnt_q <= wait_inc;
      end
      if (done_ok) begin
        rsp_valid_q[owner_q] <= 1'b1;
        rsp_rdata_q          <= pwrite_q ? '0 : prdata_i;
        rsp_slverr_q         <= pslverr_i;
      end else if (timeout_hit) begin
        rsp_valid_q[owner_q] <= 1'b1;
        rsp_rdata_q          <= '0;
        rsp_slverr_q         <= 1'b1;
      end
    end
  end

  assign paddr_o      = paddr_q;
  assign pwdata_o     = pwdata_q;
  assign pstrb_o      = pstrb_q;
  assign pwrite_o     = pwrite_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_rdata_o  = rsp_rdata_q;
  assign rsp_slverr_o = rsp_slverr_q;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Bench for apb_req_arbiter: transaction-level model checked every cycle plus
// directed scenarios with hand-computed timing and data expectations.
module tb_apb_req_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int TO = 8;
  localparam int H  = 4096;

  logic                 clk, rst;
  logic [N-1:0]         req_valid, req_ready, req_write, rsp_valid;
  logic [N-1:0][AW-1:0] req_addr;
  logic [N-1:0][DW-1:0] req_wdata;
  logic [N-1:0][SW-1:0] req_strb;
  logic [DW-1:0]        rsp_rdata;
  logic                 rsp_slverr;
  logic [AW-1:0]        paddr;
  logic                 psel, penable, pwrite;
  logic [DW-1:0]        pwdata;
  logic [SW-1:0]        pstrb;
  logic                 pready;
  logic [DW-1:0]        prdata;
  logic                 pslverr;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  apb_req_arbiter #(
    .NUM_REQ        (N),
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_addr_i   (req_addr),
    .req_wdata_i  (req_wdata),
    .req_strb_i   (req_strb),
    .req_write_i  (req_write),
    .rsp_valid_o  (rsp_valid),
    .rsp_rdata_o  (rsp_rdata),
    .rsp_slverr_o (rsp_slverr),
    .paddr_o      (paddr),
    .psel_o       (psel),
    .penable_o    (penable),
    .pwrite_o     (pwrite),
    .pwdata_o     (pwdata),
    .pstrb_o      (pstrb),
    .pready_i     (pready),
    .prdata_i     (prdata),
    .pslverr_i    (pslverr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int rr_winner(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  // Transaction-level model: a transfer is accepted, spends one cycle in
  // setup, then waits in access until pready or the stall limit.
  int            m_ptr = 0, m_owner = 0, m_age = 0, m_waits = 0, m_rsp_owner = 0;
  bit            m_busy = 0, m_rsp = 0, m_err = 0, m_write = 0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0, m_rdata = '0;
  logic [SW-1:0] m_strb = '0;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_ptr = 0; m_owner = 0; m_age = 0; m_waits = 0; m_rsp_owner = 0;
      m_busy = 0; m_rsp = 0; m_err = 0; m_write = 0;
      m_addr = '0; m_wdata = '0; m_rdata = '0; m_strb = '0;
    end else begin
      int w;
      m_rsp = 0;
      if (m_busy) begin
        if (m_age == 1) begin
          m_age = 2;
        end else if (pready === 1'b1) begin
          m_rsp = 1; m_rsp_owner = m_owner; m_err = pslverr; m_busy = 0;
          m_rdata = m_write ? '0 : prdata;
        end else begin
          m_waits++;
          if (m_waits == TO) begin
            m_rsp = 1; m_rsp_owner = m_owner; m_err = 1; m_rdata = '0; m_busy = 0;
          end
        end
      end else begin
        w = rr_winner(req_valid, m_ptr);
        if (w >= 0) begin
          m_busy = 1; m_age = 1; m_waits = 0; m_owner = w;
          m_addr = req_addr[w]; m_wdata = req_wdata[w]; m_strb = req_strb[w];
          m_write = req_write[w];
          m_ptr = (w + 1) % N;
        end
      end
    end
  end

  // Observation logs for the directed scenarios.
  int            g_cyc[$], g_idx[$], r_cyc[$];
  logic [N-1:0]  r_vec[$];
  logic [DW-1:0] r_data[$];
  logic          r_err[$];
  bit            psel_h[H];
  bit            pen_h[H];
  logic [N-1:0]  last_ready = '0;

  initial forever begin
    int           w, gi;
    logic [N-1:0] er, ev;
    @(negedge clk);
    w  = rr_winner(req_valid, m_ptr);
    er = '0;
    if (!m_busy && !rst && w >= 0) er[w] = 1'b1;
    ev = '0;
    if (m_rsp) ev[m_rsp_owner] = 1'b1;
    chk("req_ready", 64'(req_ready), 64'(er));
    chk("psel", 64'(psel), 64'(m_busy));
    chk("penable", 64'(penable), 64'(m_busy && m_age == 2));
    chk("paddr", 64'(paddr), 64'(m_addr));
    chk("pwdata", 64'(pwdata), 64'(m_wdata));
    chk("pstrb", 64'(pstrb), 64'(m_strb));
    chk("pwrite", 64'(pwrite), 64'(m_write));
    chk("rsp_valid", 64'(rsp_valid), 64'(ev));
    if (m_rsp) begin
      chk("rsp_rdata", 64'(rsp_rdata), 64'(m_rdata));
      chk("rsp_slverr", 64'(rsp_slverr), 64'(m_err));
    end
    psel_h[cyc % H] = psel;
    pen_h[cyc % H]  = penable;
    if (req_ready != '0) begin
      gi = -1;
      for (int i = 0; i < N; i++) if (req_ready[i]) gi = i;
      g_cyc.push_back(cyc);
      g_idx.push_back(gi);
    end
    if (rsp_valid != '0) begin
      r_cyc.push_back(cyc);
      r_vec.push_back(rsp_valid);
      r_data.push_back(rsp_rdata);
      r_err.push_back(rsp_slverr);
    end
    last_ready = req_ready;
  end

  // Completer: stalls wait_n ACCESS cycles then answers; wait_n < 0 never answers.
  int wait_n = 0;
  int acc_cnt = 0;
  initial begin
    pready = 1'b0;
    forever begin
      @(negedge clk);
      if (psel && penable) begin
        pready = (wait_n >= 0) && (acc_cnt >= wait_n);
        acc_cnt++;
      end else begin
        pready  = 1'b0;
        acc_cnt = 0;
      end
    end
  end

  // Requesters drop valid after acceptance unless told to keep asking.
  logic [N-1:0] hold = '0;
  initial forever begin
    logic [N-1:0] lr;
    @(posedge clk);
    lr = last_ready;
    #1;
    for (int i = 0; i < N; i++) if (lr[i] && !hold[i]) req_valid[i] = 1'b0;
  end

  task automatic clear_logs();
    g_cyc.delete(); g_idx.delete(); r_cyc.delete();
    r_vec.delete(); r_data.delete(); r_err.delete();
  endtask

  task automatic wait_grants(input int n, input int budget, input string name);
    int k = 0;
    do begin
      @(posedge clk);
      k++;
    end while (g_idx.size() < n && k < budget);
    #2;
    chk({name, "_grants_seen"}, 64'(g_idx.size() >= n), 64'd1);
  endtask

  task automatic wait_rsps(input int n, input int budget, input string name);
    int k = 0;
    do begin
      @(posedge clk);
      k++;
    end while (r_cyc.size() < n && k < budget);
    #2;
    chk({name, "_rsps_seen"}, 64'(r_cyc.size() >= n), 64'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic pen_count(input int from, input int upto, output int cnt);
    cnt = 0;
    for (int c = from; c <= upto; c++) cnt += int'(pen_h[c % H]);
  endtask

  initial begin
    int g, r, cnt, k;
    int exp_ord[5] = '{0, 1, 2, 3, 0};
    rst = 1'b0; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    req_strb = '0; prdata = '0; pslverr = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_psel", 64'(psel), 64'd0);
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_paddr", 64'(paddr), 64'd0);
    rst = 1'b0;

    // Single read with zero wait states.
    clear_logs();
    wait_n = 0; prdata = 32'hDEAD_BEEF; pslverr = 1'b0;
    req_addr[0] = 32'h10; req_write[0] = 1'b0; req_valid[0] = 1'b1;
    wait_grants(1, 10, "s1");
    wait_rsps(1, 10, "s1");
    if (g_idx.size() >= 1 && r_cyc.size() >= 1) begin
      g = g_cyc[0];
      chk("s1_grant_idx", 64'(g_idx[0]), 64'd0);
      chk("s1_setup_psel", 64'(psel_h[(g + 1) % H]), 64'd1);
      chk("s1_setup_pen", 64'(pen_h[(g + 1) % H]), 64'd0);
      chk("s1_access_pen", 64'(pen_h[(g + 2) % H]), 64'd1);
      chk("s1_rsp_latency", 64'(r_cyc[0] - g), 64'd3);
      chk("s1_rsp_vec", 64'(r_vec[0]), 64'h1);
      chk("s1_rdata", 64'(r_data[0]), 64'hDEAD_BEEF);
      chk("s1_slverr", 64'(r_err[0]), 64'd0);
    end

    // All requesters asking continuously from reset.
    do_reset();
    clear_logs();
    wait_n = 0; prdata = 32'h0000_1111;
    hold = '1;
    for (int i = 0; i < N; i++) begin
      req_addr[i] = AW'(32'h100 * i); req_write[i] = 1'b0;
    end
    req_valid = '1;
    wait_grants(5, 30, "s2");
    hold = '0; req_valid = '0;
    wait_rsps(5, 10, "s2");
    if (g_idx.size() >= 5) begin
      for (int i = 0; i < 5; i++) begin
        chk($sformatf("s2_order%0d", i), 64'(g_idx[i]), 64'(exp_ord[i]));
        if (i > 0) chk($sformatf("s2_spacing%0d", i), 64'(g_cyc[i] - g_cyc[i-1]), 64'd3);
      end
    end
    if (r_cyc.size() >= 5) chk("s2_last_rsp_vec", 64'(r_vec[4]), 64'h1);

    // Write with five stalled ACCESS cycles.
    clear_logs();
    wait_n = 5; prdata = 32'hFFFF_0000;
    req_addr[2] = 32'h2000_0040; req_wdata[2] = 32'hA5A5_1234; req_strb[2] = 4'b0110;
    req_write[2] = 1'b1; req_valid[2] = 1'b1;
    wait_grants(1, 10, "s3");
    wait_rsps(1, 20, "s3");
    if (g_idx.size() >= 1 && r_cyc.size() >= 1) begin
      g = g_cyc[0]; r = r_cyc[0];
      pen_count(g + 1, r - 1, cnt);
      chk("s3_penable_cycles", 64'(cnt), 64'd6);
      chk("s3_rsp_latency", 64'(r - g), 64'd8);
      chk("s3_rsp_vec", 64'(r_vec[0]), 64'h4);
      chk("s3_write_rdata", 64'(r_data[0]), 64'd0);
      chk("s3_slverr", 64'(r_err[0]), 64'd0);
    end
    repeat (3) @(posedge clk);
    #2;
    chk("s3_single_rsp", 64'(r_cyc.size()), 64'd1);
    chk("s3_paddr_hold", 64'(paddr), 64'h2000_0040);
    chk("s3_pwdata_hold", 64'(pwdata), 64'hA5A5_1234);

    // Completer never answers: stall limit ends the transfer.
    clear_logs();
    wait_n = -1; prdata = 32'h1234_5678;
    req_addr[1] = 32'h44; req_write[1] = 1'b0; req_valid[1] = 1'b1;
    wait_grants(1, 10, "s4");
    wait_rsps(1, 30, "s4");
    if (g_idx.size() >= 1 && r_cyc.size() >= 1) begin
      g = g_cyc[0]; r = r_cyc[0];
      pen_count(g + 1, r - 1, cnt);
      chk("s4_access_cycles", 64'(cnt), 64'd8);
      chk("s4_rsp_latency", 64'(r - g), 64'd10);
      chk("s4_psel_dropped", 64'(psel_h[r % H]), 64'd0);
      chk("s4_slverr", 64'(r_err[0]), 64'd1);
      chk("s4_rdata", 64'(r_data[0]), 64'd0);
      chk("s4_rsp_vec", 64'(r_vec[0]), 64'h2);
    end

    // Reset during ACCESS aborts silently and restarts arbitration at req0.
    clear_logs();
    wait_n = -1;
    req_addr[1] = 32'h50; req_write[1] = 1'b0; req_valid[1] = 1'b1;
    wait_grants(1, 10, "s5a");
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (penable !== 1'b1 && k < 10);
    chk("s5_reached_access", 64'(penable), 64'd1);
    #1 rst = 1'b1;
    #1;
    chk("s5_async_psel", 64'(psel), 64'd0);
    chk("s5_async_penable", 64'(penable), 64'd0);
    chk("s5_async_paddr", 64'(paddr), 64'd0);
    clear_logs();
    wait_n = 0; prdata = 32'h0000_5555;
    req_addr[0] = 32'h60; req_write[0] = 1'b0;
    req_addr[2] = 32'h70; req_write[2] = 1'b0;
    req_valid[0] = 1'b1; req_valid[2] = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    wait_grants(2, 20, "s5b");
    wait_rsps(2, 20, "s5b");
    if (g_idx.size() >= 2) begin
      chk("s5_first_after_rst", 64'(g_idx[0]), 64'd0);
      chk("s5_second_after_rst", 64'(g_idx[1]), 64'd2);
    end
    if (r_cyc.size() >= 2) begin
      chk("s5_rsp0_vec", 64'(r_vec[0]), 64'h1);
      chk("s5_rsp1_vec", 64'(r_vec[1]), 64'h4);
    end

    // Completer error goes to its owner only; the next transfer is clean.
    clear_logs();
    wait_n = 0; prdata = 32'hCAFE_0001; pslverr = 1'b1;
    req_addr[1] = 32'h80; req_write[1] = 1'b0; req_valid[1] = 1'b1;
    wait_rsps(1, 10, "s6a");
    pslverr = 1'b0; prdata = 32'h0BAD_F00D;
    req_addr[2] = 32'h90; req_write[2] = 1'b0; req_valid[2] = 1'b1;
    wait_rsps(2, 10, "s6b");
    if (r_cyc.size() >= 2) begin
      chk("s6_err_vec", 64'(r_vec[0]), 64'h2);
      chk("s6_err_flag", 64'(r_err[0]), 64'd1);
      chk("s6_err_rdata", 64'(r_data[0]), 64'hCAFE_0001);
      chk("s6_next_vec", 64'(r_vec[1]), 64'h4);
      chk("s6_next_flag", 64'(r_err[1]), 64'd0);
      chk("s6_next_rdata", 64'(r_data[1]), 64'h0BAD_F00D);
    end

    repeat (4) @(posedge clk);
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish by 50000");
    $fatal(1, "watchdog");
  end

endmodule
